// File: rtl/mem_arbiter_if.sv
// Bundle of requester (IF, D, LD) and downstream memory-port signals for mem_arbiter.
// The arbiter connects through modport master; requesters and memory connect through modport slave.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_done;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        rbusy;
    logic        err;
    logic [1:0]  gnt_id;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_done,
        input  ld_req, ld_addr, ld_wdata,
        output ld_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata,
        output rbusy, err, gnt_id
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_done,
        output ld_req, ld_addr, ld_wdata,
        input  ld_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata,
        input  rbusy, err, gnt_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the DMA memory port between CPU fetch (IF), CPU load/store (D) and the boot loader (LD).
// LD has fixed priority, IF/D alternate; every transfer is bounded by a BUSY-cycle timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.master bus
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2, OWN_LD = 2'd3} owner_t;

    state_t        state, state_nx;
    owner_t        owner, grant_nx;
    logic          last_d;
    logic          err_flag;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // last_d=1 means D was served last, so IF wins the next IF/D tie
    always_comb begin
        grant_nx = OWN_NONE;
        if (bus.ld_req)
            grant_nx = OWN_LD;
        else if (bus.if_req && bus.d_req)
            grant_nx = last_d ? OWN_IF : OWN_D;
        else if (bus.if_req)
            grant_nx = OWN_IF;
        else if (bus.d_req)
            grant_nx = OWN_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.mem_req  = 1'b0;
        bus.if_done  = 1'b0;
        bus.d_done   = 1'b0;
        bus.ld_done  = 1'b0;
        bus.err      = 1'b0;
        case (state)
            IDLE: if (grant_nx != OWN_NONE) state_nx = BUSY;
            BUSY: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready || timeout_hit) state_nx = DONE;
            end
            DONE: begin
                state_nx    = IDLE;
                bus.if_done = (owner == OWN_IF);
                bus.d_done  = (owner == OWN_D);
                bus.ld_done = (owner == OWN_LD);
                bus.err     = err_flag;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.gnt_id = owner;
    assign bus.rbusy  = (state != IDLE) || bus.if_req || bus.d_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner         <= OWN_NONE;
            last_d        <= 1'b1;
            err_flag      <= 1'b0;
            cnt           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (grant_nx != OWN_NONE) begin
                    owner    <= grant_nx;
                    cnt      <= '0;
                    err_flag <= 1'b0;
                    case (grant_nx)
                        OWN_LD: begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= bus.ld_addr;
                            bus.mem_wdata <= bus.ld_wdata;
                            bus.mem_be    <= 4'b1111;
                        end
                        OWN_IF: begin
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_be    <= 4'b1111;
                        end
                        default: begin
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_be    <= bus.d_be;
                        end
                    endcase
                end
                BUSY: begin
                    // ready takes precedence over a timeout landing on the same edge
                    if (bus.mem_ready) begin
                        if (!bus.mem_we && owner == OWN_IF) bus.if_rdata <= bus.mem_rdata;
                        if (!bus.mem_we && owner == OWN_D)  bus.d_rdata  <= bus.mem_rdata;
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                        if (owner == OWN_IF)                bus.if_rdata <= NOP_WORD;
                        if (owner == OWN_D && !bus.mem_we)  bus.d_rdata  <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (owner == OWN_IF) last_d <= 1'b0;
                    if (owner == OWN_D)  last_d <= 1'b1;
                    owner    <= OWN_NONE;
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
